// File: rtl/color_mask_pkg.sv
// Shared pixel/range types and counter sizing for the streaming colour-mask pipeline.
package color_mask_pkg;

  localparam int N_CH = 3;
  localparam int CH_W = 8;

  typedef logic [N_CH-1:0][CH_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t lower;
    pixel_t upper;
  } range_t;

  function automatic int cnt_width(input int height, input int length);
    return $clog2(height * length + 1);
  endfunction

endpackage

// File: rtl/color_range_cmp.sv
// One colour-box test: per-channel inclusive bounds check, forced low when the box is disabled.
module color_range_cmp
  import color_mask_pkg::*;
(
  input  pixel_t            i_pixel,
  input  range_t            i_range,
  input  logic              i_en,
  output logic [N_CH-1:0]   o_in_range
);

  always_comb begin
    o_in_range = '0;
    for (int c = 0; c < N_CH; c++) begin
      o_in_range[c] = i_en && (i_pixel[c] >= i_range.lower[c]) && (i_pixel[c] <= i_range.upper[c]);
    end
  end

endmodule

// File: rtl/stream_color_mask.sv
// Two-stage valid/ready pipeline producing a per-pixel colour-box mask, with frame geometry
// tracking, per-frame match counting and a frame-done pulse.
module stream_color_mask
  import color_mask_pkg::*;
#(
  parameter int N_RANGES = 2,
  parameter int HEIGHT   = 2,
  parameter int LENGTH   = 4,
  parameter int CNT_W    = cnt_width(HEIGHT, LENGTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  pixel_t [N_RANGES-1:0]      cfg_lower,
  input  pixel_t [N_RANGES-1:0]      cfg_upper,
  input  logic   [N_RANGES-1:0]      cfg_range_en,
  input  logic                       cfg_invert,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  pixel_t                     s_pixel,
  input  logic                       s_sof,
  input  logic                       s_eol,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_mask,
  output logic                       m_sof,
  output logic                       m_eol,
  output logic                       frame_done,
  output logic [CNT_W-1:0]           match_count,
  output logic                       frame_error
);

  localparam int COL_W = $clog2(LENGTH + 1);
  localparam int ROW_W = $clog2(HEIGHT + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LENGTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  logic                             r_alive;
  range_t [N_RANGES-1:0]            r_range_sh;
  logic   [N_RANGES-1:0]            r_en_sh;
  logic                             r_inv_sh;
  range_t [N_RANGES-1:0]            w_range;
  logic   [N_RANGES-1:0]            w_en;
  logic                             w_inv;
  logic   [N_RANGES-1:0][N_CH-1:0]  w_cmp;
  logic                             w_s2_ready, w_s1_load, w_acc, w_take_cfg, w_out;

  logic [COL_W-1:0]                 r_col, w_pos_col;
  logic [ROW_W-1:0]                 r_row, w_pos_row;
  logic                             r_framed, r_complete, r_frame_err;
  logic                             w_last, w_sof_err, w_eol_err;

  logic [N_RANGES-1:0][N_CH-1:0]    r_cmp_p1;
  logic                             r_vld_p1, r_inv_p1, r_sof_p1, r_eol_p1, r_last_p1;
  logic                             w_match_p1;
  logic                             r_vld_p2, r_mask_p2, r_match_p2, r_sof_p2, r_eol_p2, r_last_p2;

  logic [CNT_W-1:0]                 r_run, r_match_cnt, w_base, w_sum;
  logic                             r_frame_done;

  assign w_s2_ready = !r_vld_p2 || m_ready;
  assign w_s1_load  = !r_vld_p1 || w_s2_ready;
  assign s_ready    = r_alive && w_s1_load;
  assign w_acc      = s_valid && s_ready;
  assign w_take_cfg = w_acc && s_sof;
  assign w_out      = r_vld_p2 && m_ready;

  // The SOF beat itself must see the new configuration, so bypass the shadow on that beat.
  always_comb begin
    w_range = r_range_sh;
    w_en    = r_en_sh;
    w_inv   = r_inv_sh;
    if (w_take_cfg) begin
      for (int r = 0; r < N_RANGES; r++) begin
        w_range[r] = range_t'({cfg_lower[r], cfg_upper[r]});
      end
      w_en  = cfg_range_en;
      w_inv = cfg_invert;
    end
  end

  for (genvar r = 0; r < N_RANGES; r++) begin : g_rng
    color_range_cmp u_cmp (
      .i_pixel    (s_pixel),
      .i_range    (w_range[r]),
      .i_en       (w_en[r]),
      .o_in_range (w_cmp[r])
    );
  end

  always_comb begin
    w_pos_col = s_sof ? '0 : r_col;
    w_pos_row = s_sof ? '0 : r_row;
    w_last    = (s_sof || r_framed) && (w_pos_row == LAST_ROW) && (w_pos_col == LAST_COL);
    w_sof_err = s_sof && r_framed && !r_complete && ((r_row != '0) || (r_col != '0));
    w_eol_err = s_eol && (w_pos_col != LAST_COL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive     <= 1'b0;
      r_range_sh  <= '0;
      r_en_sh     <= '0;
      r_inv_sh    <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_framed    <= 1'b0;
      r_complete  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (w_take_cfg) begin
        r_range_sh <= w_range;
        r_en_sh    <= w_en;
        r_inv_sh   <= w_inv;
      end
      if (w_acc) begin
        r_framed <= r_framed | s_sof;
        if (s_eol) begin
          r_col <= '0;
          r_row <= w_pos_row + 1'b1;
        end else begin
          r_col <= w_pos_col + 1'b1;
          r_row <= w_pos_row;
        end
        if (w_last)     r_complete <= 1'b1;
        else if (s_sof) r_complete <= 1'b0;
        if (s_sof)                       r_frame_err <= w_sof_err || w_eol_err;
        else if (w_eol_err || !r_framed) r_frame_err <= 1'b1;
      end
    end
  end

  // ---- S1: per-range / per-channel compare bits ----
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_cmp_p1  <= w_cmp;
      r_inv_p1  <= w_inv;
      r_sof_p1  <= s_sof;
      r_eol_p1  <= s_eol;
      r_last_p1 <= w_last;
    end
  end

  always_comb begin
    w_match_p1 = 1'b0;
    for (int r = 0; r < N_RANGES; r++) begin
      if (&r_cmp_p1[r]) w_match_p1 = 1'b1;
    end
  end

  // ---- S2: OR-reduce, polarity select, output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_mask_p2  <= 1'b0;
      r_match_p2 <= 1'b0;
      r_sof_p2   <= 1'b0;
      r_eol_p2   <= 1'b0;
      r_last_p2  <= 1'b0;
    end else begin
      if (w_s1_load)  r_vld_p1 <= w_acc;
      if (w_s2_ready) r_vld_p2 <= r_vld_p1;
      if (w_s2_ready && r_vld_p1) begin
        r_mask_p2  <= ~(w_match_p1 ^ r_inv_p1);
        r_match_p2 <= w_match_p1;
        r_sof_p2   <= r_sof_p1;
        r_eol_p2   <= r_eol_p1;
        r_last_p2  <= r_last_p1;
      end
    end
  end

  // An output SOF restarts the running count so stray pre-frame beats never leak into it.
  assign w_base = r_sof_p2 ? '0 : r_run;
  assign w_sum  = w_base + CNT_W'(r_match_p2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run        <= '0;
      r_match_cnt  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_out) begin
        if (r_last_p2) begin
          r_match_cnt  <= w_sum;
          r_run        <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_run <= w_sum;
        end
      end
    end
  end

  assign m_valid     = r_vld_p2;
  assign m_mask      = r_mask_p2;
  assign m_sof       = r_sof_p2;
  assign m_eol       = r_eol_p2;
  assign frame_done  = r_frame_done;
  assign match_count = r_match_cnt;
  assign frame_error = r_frame_err;

endmodule

// File: tb/tb_stream_color_mask.sv
// Directed and randomized bench for stream_color_mask against a queue-based reference model.
module tb_stream_color_mask;
  import color_mask_pkg::*;

  localparam int NR = 2;
  localparam int H  = 2;
  localparam int L  = 4;
  localparam int CW = cnt_width(H, L);

  logic              clk, rst_n;
  pixel_t [NR-1:0]   cfg_lower, cfg_upper;
  logic   [NR-1:0]   cfg_range_en;
  logic              cfg_invert;
  logic              s_valid, s_ready, s_sof, s_eol;
  pixel_t            s_pixel;
  logic              m_valid, m_ready, m_mask, m_sof, m_eol, frame_done, frame_error;
  logic   [CW-1:0]   match_count;

  stream_color_mask #(.N_RANGES(NR), .HEIGHT(H), .LENGTH(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_lower(cfg_lower), .cfg_upper(cfg_upper), .cfg_range_en(cfg_range_en), .cfg_invert(cfg_invert),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel), .s_sof(s_sof), .s_eol(s_eol),
    .m_valid(m_valid), .m_ready(m_ready), .m_mask(m_mask), .m_sof(m_sof), .m_eol(m_eol),
    .frame_done(frame_done), .match_count(match_count), .frame_error(frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic mask; logic sof; logic eol; logic last; } beat_t;

  beat_t           q[$];
  int              cq[$];
  int              n_pass = 0, n_fail = 0;
  int              n_out = 0, n_ones = 0, n_fd = 0, fd_beat = 0;
  bit              rnd_ready = 0, last_acc = 0;
  pixel_t [NR-1:0] sh_lo, sh_hi;
  logic   [NR-1:0] sh_en;
  bit              sh_inv, m_framed;
  int              m_row, m_col, m_fcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pixel_t mkpix(input int a, input int b, input int c);
    pixel_t p;
    p[0] = CH_W'(a); p[1] = CH_W'(b); p[2] = CH_W'(c);
    return p;
  endfunction

  function automatic pixel_t rpix();
    pixel_t p;
    for (int c = 0; c < N_CH; c++) p[c] = CH_W'($urandom_range(0, 255));
    return p;
  endfunction

  function automatic bit model_match(input pixel_t px);
    for (int r = 0; r < NR; r++) begin
      if (sh_en[r]) begin
        bit inside_box;
        inside_box = 1;
        for (int c = 0; c < N_CH; c++)
          if (px[c] < sh_lo[r][c] || px[c] > sh_hi[r][c]) inside_box = 0;
        if (inside_box) return 1;
      end
    end
    return 0;
  endfunction

  function automatic void model_reset();
    q.delete(); cq.delete();
    sh_lo = '0; sh_hi = '0; sh_en = '0; sh_inv = 0;
    m_framed = 0; m_row = 0; m_col = 0; m_fcnt = 0;
  endfunction

  function automatic void model_accept(input pixel_t px, input logic sof, input logic eol);
    bit match, last;
    beat_t b;
    if (sof) begin
      sh_lo = cfg_lower; sh_hi = cfg_upper; sh_en = cfg_range_en; sh_inv = cfg_invert;
      m_framed = 1; m_row = 0; m_col = 0; m_fcnt = 0;
    end
    match  = model_match(px);
    last   = m_framed && (m_row == H - 1) && (m_col == L - 1);
    m_fcnt = m_fcnt + int'(match);
    b.mask = sh_inv ? match : !match;
    b.sof  = sof; b.eol = eol; b.last = last;
    q.push_back(b);
    if (last) cq.push_back(m_fcnt);
    if (eol) begin m_row++; m_col = 0; end
    else m_col++;
  endfunction

  task automatic tick();
    logic       acc, ob, hold, fd_exp;
    logic [3:0] snap;
    beat_t      e;
    int         mc_exp;
    if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    #1;
    acc  = s_valid && s_ready;
    ob   = m_valid && m_ready;
    hold = m_valid && !m_ready;
    snap = {m_valid, m_mask, m_sof, m_eol};
    if (acc) model_accept(s_pixel, s_sof, s_eol);
    fd_exp = 0; mc_exp = 0;
    if (ob) begin
      chk("beat_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("mask", 32'(snap[2]), 32'(e.mask));
        chk("sof", 32'(snap[1]), 32'(e.sof));
        chk("eol", 32'(snap[0]), 32'(e.eol));
        if (e.last && cq.size() != 0) begin fd_exp = 1; mc_exp = cq.pop_front(); end
        n_out++;
        if (snap[2]) n_ones++;
      end
    end
    @(posedge clk); #1;
    last_acc = acc;
    chk("frame_done", 32'(frame_done), 32'(fd_exp));
    if (fd_exp) chk("match_count", 32'(match_count), mc_exp);
    if (frame_done) begin n_fd++; fd_beat = n_out; end
    if (hold) chk("stall_stable", 32'({m_valid, m_mask, m_sof, m_eol}), 32'(snap));
  endtask

  task automatic send(input pixel_t px, input logic sof, input logic eol);
    int n = 0;
    s_valid = 1; s_pixel = px; s_sof = sof; s_eol = eol;
    do begin tick(); n++; end while (!last_acc && n < 200);
    chk("accept_timeout", 32'(last_acc), 1);
  endtask

  task automatic drain();
    int n = 0;
    s_valid = 0; s_sof = 0; s_eol = 0;
    while (q.size() != 0 && n < 500) begin tick(); n++; end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic set_green();
    cfg_lower    = '0; cfg_upper = '0;
    cfg_lower[0] = mkpix(0, 100, 0);
    cfg_upper[0] = mkpix(80, 255, 80);
    cfg_range_en = 2'b01;
    cfg_invert   = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pixel_t px;
    int     base, fd0, ones0;
    rst_n = 1; s_valid = 0; s_pixel = '0; s_sof = 0; s_eol = 0; m_ready = 1;
    cfg_lower = '0; cfg_upper = '0; cfg_range_en = '0; cfg_invert = 0;
    model_reset();

    // Reset values
    #1 rst_n = 0;
    #1;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_outputs", 32'({m_mask, m_sof, m_eol, frame_done, frame_error}), 0);
    chk("rst_match_count", 32'(match_count), 0);
    @(posedge clk); #1 rst_n = 1;
    tick(); tick();
    chk("post_rst_s_ready", 32'(s_ready), 1);
    chk("post_rst_m_valid", 32'(m_valid), 0);

    // Green box, latency and first masks
    set_green();
    for (int k = 0; k < H * L; k++) begin
      px = (k == 0) ? mkpix(10, 200, 10) : (k == 1) ? mkpix(200, 200, 10) : rpix();
      send(px, k == 0, (k % L) == L - 1);
      if (k == 0) chk("lat_1clk_m_valid", 32'(m_valid), 0);
      if (k == 1) begin
        chk("lat_2clk_m_valid", 32'(m_valid), 1);
        chk("green_in_mask", 32'(m_mask), 0);
      end
      if (k == 2) chk("green_out_mask", 32'(m_mask), 1);
    end
    drain();

    // Full frame, 5 matching pixels
    base = n_out; fd0 = n_fd;
    for (int k = 0; k < H * L; k++) begin
      px = (k < 5) ? mkpix(20, 150, 30) : mkpix(200, 10, 10);
      send(px, k == 0, (k % L) == L - 1);
    end
    drain();
    chk("t3_fd_pulses", n_fd - fd0, 1);
    chk("t3_fd_beat", fd_beat - base, 8);
    chk("t3_match_count", 32'(match_count), 5);
    chk("t3_frame_error", 32'(frame_error), 0);

    // Mid-frame invert change only takes effect at the next SOF
    ones0 = n_ones;
    for (int k = 0; k < H * L; k++) begin
      if (k == 4) cfg_invert = 1;
      send(mkpix(20, 150, 30), k == 0, (k % L) == L - 1);
    end
    drain();
    chk("t5_frame_a_ones", n_ones - ones0, 0);
    ones0 = n_ones;
    for (int k = 0; k < H * L; k++) send(mkpix(20, 150, 30), k == 0, (k % L) == L - 1);
    drain();
    chk("t5_frame_b_ones", n_ones - ones0, 8);

    // Short row: EOL at column 2
    set_green();
    for (int k = 0; k < 7; k++) begin
      send(rpix(), k == 0, (k == 2) || (k == 6));
      if (k == 0) chk("t6_err_before", 32'(frame_error), 0);
      if (k == 2) chk("t6_err_set", 32'(frame_error), 1);
    end
    drain();
    chk("t6_err_held", 32'(frame_error), 1);
    for (int k = 0; k < H * L; k++) begin
      send(rpix(), k == 0, (k % L) == L - 1);
      if (k == 0) chk("t6_err_cleared", 32'(frame_error), 0);
    end
    drain();

    // Random frames, random configs, random backpressure and input gaps
    rnd_ready = 1;
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < N_CH; c++) begin
          cfg_lower[r][c] = CH_W'($urandom_range(0, 100));
          cfg_upper[r][c] = CH_W'($urandom_range(80, 255));
        end
      cfg_range_en = NR'($urandom_range(0, 3));
      cfg_invert   = 1'($urandom_range(0, 1));
      for (int k = 0; k < H * L; k++) begin
        if ($urandom_range(0, 3) == 0) begin s_valid = 0; tick(); end
        send(rpix(), k == 0, (k % L) == L - 1);
      end
    end
    drain();
    chk("rand_frame_error", 32'(frame_error), 0);
    rnd_ready = 0; m_ready = 1;

    // Reset asserted with beats in flight
    m_ready = 0;
    send(rpix(), 1, 0);
    send(rpix(), 0, 0);
    s_valid = 0;
    chk("midrst_full", 32'(m_valid), 1);
    rst_n = 0;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 0);
    chk("midrst_s_ready", 32'(s_ready), 0);
    chk("midrst_match_count", 32'(match_count), 0);
    chk("midrst_frame_error", 32'(frame_error), 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1; m_ready = 1;
    tick(); tick();
    chk("midrst_after_s_ready", 32'(s_ready), 1);
    chk("midrst_after_m_valid", 32'(m_valid), 0);

    // Data before the first SOF
    send(mkpix(20, 150, 30), 0, 0);
    chk("presof_err", 32'(frame_error), 1);
    drain();
    set_green();
    for (int k = 0; k < H * L; k++) begin
      send(rpix(), k == 0, (k % L) == L - 1);
      if (k == 0) chk("presof_err_cleared", 32'(frame_error), 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
